fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch front end.
//
// Each instruction is fetched with a four-state sequence:
//   T1_ADDR  MAR <= PC
//   T2_INC   PC  <= PC + 1 (wraps at 2^AddressSize)
//   T3_READ  ROM enabled, IR <= rom_data at the end of the cycle
//   HOLD     IR is presented to the execute stage until it is accepted.
// If the accepted word has an all-ones opcode (HLT), the unit parks in HALT.
// Only reset leaves HALT.
//
// Ports
//   CLK           system clock, rising edge
//   CLR_bar       asynchronous active-low reset
//   rom_address   ROM address (always the MAR)
//   rom_CE_bar    ROM chip enable, active-low, low only in T3_READ
//   rom_data      ROM read data
//   instr_valid   IR holds a word for the execute stage (HOLD)
//   instr_ready   execute stage accepts the presented word
//   opcode        upper half of IR
//   operand       lower half of IR
//   jump_en       on an accepted non-HLT handshake, load PC from jump_address
//   jump_address  branch target
//   pc_value      current program counter
//   halted        HLT accepted, fetch stopped
//
// WordSize is expected to be even so that opcode and operand split IR evenly.
module fetch_unit #(
  parameter int WordSize    = 8,
  parameter int AddressSize = 4
) (
  input  logic                    CLK,
  input  logic                    CLR_bar,
  output logic [AddressSize-1:0]  rom_address,
  output logic                    rom_CE_bar,
  input  logic [WordSize-1:0]     rom_data,
  output logic                    instr_valid,
  input  logic                    instr_ready,
  output logic [WordSize/2-1:0]   opcode,
  output logic [WordSize/2-1:0]   operand,
  input  logic                    jump_en,
  input  logic [AddressSize-1:0]  jump_address,
  output logic [AddressSize-1:0]  pc_value,
  output logic                    halted
);

  typedef enum logic [2:0] {
    T1_ADDR = 3'd0,
    T2_INC  = 3'd1,
    T3_READ = 3'd2,
    HOLD    = 3'd3,
    HALT    = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [AddressSize-1:0]  pc_q,    pc_d;
  logic [AddressSize-1:0]  mar_q,   mar_d;
  logic [WordSize-1:0]     ir_q,    ir_d;
  logic                    ce_bar_q, ce_bar_d;
  logic                    valid_q,  valid_d;
  logic                    halted_q, halted_d;

  logic                    is_hlt;

  assign opcode  = ir_q[WordSize-1 -: WordSize/2];
  assign operand = ir_q[WordSize/2-1:0];
  assign is_hlt  = &opcode;

  // Next-state and datapath updates. Every register holds by default, so
  // HOLD without a handshake and HALT change nothing.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mar_d   = mar_q;
    ir_d    = ir_q;
    unique case (state_q)
      T1_ADDR: begin
        mar_d   = pc_q;
        state_d = T2_INC;
      end
      T2_INC: begin
        pc_d    = pc_q + AddressSize'(1);
        state_d = T3_READ;
      end
      T3_READ: begin
        ir_d    = rom_data;
        state_d = HOLD;
      end
      HOLD: begin
        if (instr_ready) begin
          if (is_hlt) begin
            // HLT wins over any jump request presented with it.
            state_d = HALT;
          end else begin
            state_d = T1_ADDR;
            if (jump_en) pc_d = jump_address;
          end
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        // Unused encodings fall back into the fetch loop.
        state_d = T1_ADDR;
      end
    endcase
  end

  // Status outputs are decoded from the next state and registered, so they
  // are exact decodes of the current state with no input-to-output path and
  // no decode glitches on the ROM enable.
  always_comb begin
    ce_bar_d = (state_d != T3_READ);
    valid_d  = (state_d == HOLD);
    halted_d = (state_d == HALT);
  end

  always_ff @(posedge CLK or negedge CLR_bar) begin
    if (!CLR_bar) begin
      state_q  <= T1_ADDR;
      pc_q     <= '0;
      mar_q    <= '0;
      ir_q     <= '0;
      ce_bar_q <= 1'b1;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      mar_q    <= mar_d;
      ir_q     <= ir_d;
      ce_bar_q <= ce_bar_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  assign rom_address = mar_q;
  assign rom_CE_bar  = ce_bar_q;
  assign instr_valid = valid_q;
  assign halted      = halted_q;
  assign pc_value    = pc_q;

endmodule
